// File: rtl/anabellek_blok_okuyucu_pkg.sv
// anabellek_paket: shared widths, FSM state type and the word address helper
// for the block refill responder and its slot register.
// No ports (package). Optional feature macro used by the top: KRITIK_SOZCUK_ONCE_EN.
package anabellek_paket;

   localparam int unsigned ADRES_BIT     = 32;
   localparam int unsigned VERI_BIT      = 32;
   localparam int unsigned BLOK_BIT      = 128;
   localparam int unsigned SOZCUK_SAYISI = BLOK_BIT / VERI_BIT;
   localparam int unsigned SIRA_BIT      = $clog2(SOZCUK_SAYISI);
   localparam int unsigned OFSET_BIT     = $clog2(BLOK_BIT / 8);
   localparam int unsigned KELIME_OFSET  = $clog2(VERI_BIT / 8);

   typedef enum logic [1:0] {
      BOSTA       = 2'b00,
      ISTEK       = 2'b01,
      YANIT_BEKLE = 2'b10,
      TAMAM       = 2'b11
   } durum_t;

   // Word address inside a block; plain modular 32-bit addition, no carry out.
   function automatic logic [ADRES_BIT-1:0] kelime_adresi(
      input logic [ADRES_BIT-1:0] taban,
      input logic [SIRA_BIT-1:0]  sira
   );
      return taban + ADRES_BIT'({sira, {KELIME_OFSET{1'b0}}});
   endfunction

endpackage

// File: rtl/anabellek_blok_okuyucu_blok_toplayici.sv
// blok_toplayici: 4 x 32-bit slot register that assembles a cache block.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   temizle    : clear all slots (priority over yaz)
//   yaz        : write veri into slot sira
//   sira       : slot index
//   veri       : word to store
//   blok       : assembled block, slot k at bits [32k+31:32k]
module blok_toplayici
   import anabellek_paket::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                temizle,
   input  logic                yaz,
   input  logic [SIRA_BIT-1:0] sira,
   input  logic [VERI_BIT-1:0] veri,
   output logic [BLOK_BIT-1:0] blok
);

   logic [SOZCUK_SAYISI-1:0][VERI_BIT-1:0] yuva;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         yuva <= '0;
      end else if (temizle) begin
         yuva <= '0;
      end else if (yaz) begin
         yuva[sira] <= veri;
      end
   end

   assign blok = yuva;

endmodule

// File: rtl/anabellek_blok_okuyucu.sv
// anabellek_blok_okuyucu: serves one 128-bit block read from the instruction
// cache controller by issuing four 32-bit word reads on a valid/ready memory
// port, then pulses hazir for one cycle with the assembled block.
// Ports:
//   clk_i, rst_ni                          : clock, asynchronous active-low reset
//   anabellek_denetleyici_okuma_istek_*    : block request (level valid, address)
//   anabellek_denetleyici_okuma_veri_blok_o: assembled block
//   anabellek_denetleyici_okuma_istek_hazir_o : one-cycle block-valid pulse
//   bellek_istek_*                         : word read request to memory
//   bellek_yanit_*                         : word read response from memory
// Macro KRITIK_SOZCUK_ONCE_EN: start word order at the requested word and
// wrap modulo 4; undefined gives order 0,1,2,3.
module anabellek_blok_okuyucu
   import anabellek_paket::*;
(
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [ADRES_BIT-1:0] anabellek_denetleyici_okuma_istek_adres_i,
   input  logic                 anabellek_denetleyici_okuma_istek_gecerli_i,
   output logic [BLOK_BIT-1:0]  anabellek_denetleyici_okuma_veri_blok_o,
   output logic                 anabellek_denetleyici_okuma_istek_hazir_o,
   output logic [ADRES_BIT-1:0] bellek_istek_adres_o,
   output logic                 bellek_istek_gecerli_o,
   input  logic                 bellek_istek_hazir_i,
   input  logic [VERI_BIT-1:0]  bellek_yanit_veri_i,
   input  logic                 bellek_yanit_gecerli_i
);

   localparam int unsigned BLOK_NO_BIT = ADRES_BIT - OFSET_BIT;

   durum_t                 durum;
   logic [ADRES_BIT-1:0]   taban;
   logic [BLOK_NO_BIT-1:0] sunulan_blok;
   logic [SIRA_BIT-1:0]    sayac;
   logic [SIRA_BIT-1:0]    sayac_sonraki;
   logic [SIRA_BIT-1:0]    sira;
   logic [SIRA_BIT-1:0]    baslangic;
   logic [SIRA_BIT-1:0]    baslangic_giris;
   logic [ADRES_BIT-1:0]   giris_taban;
   logic                   yeniden_hazir;
   logic                   farkli_blok;
   logic                   kabul;
   logic                   yaz;
   logic                   unused_ofset;

   assign giris_taban = {anabellek_denetleyici_okuma_istek_adres_i[ADRES_BIT-1:OFSET_BIT],
                         {OFSET_BIT{1'b0}}};
   assign farkli_blok = anabellek_denetleyici_okuma_istek_adres_i[ADRES_BIT-1:OFSET_BIT]
                        != sunulan_blok;
   // The stored flag covers an earlier drop of valid; a changed block address
   // re-arms in the same cycle so a new request starts without a bubble.
   assign kabul = (durum == BOSTA) && anabellek_denetleyici_okuma_istek_gecerli_i
                  && (yeniden_hazir || farkli_blok);
   assign yaz           = (durum == YANIT_BEKLE) && bellek_yanit_gecerli_i;
   assign sayac_sonraki = sayac + 1'b1;
   assign sira          = sayac + baslangic;
   assign unused_ofset  = ^anabellek_denetleyici_okuma_istek_adres_i[OFSET_BIT-1:0];

`ifdef KRITIK_SOZCUK_ONCE_EN
   assign baslangic_giris =
      anabellek_denetleyici_okuma_istek_adres_i[OFSET_BIT-1:KELIME_OFSET];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         baslangic <= '0;
      end else if (kabul) begin
         baslangic <= baslangic_giris;
      end
   end
`else
   assign baslangic_giris = '0;
   assign baslangic       = '0;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         durum                                     <= BOSTA;
         taban                                     <= '0;
         sunulan_blok                              <= '0;
         sayac                                     <= '0;
         yeniden_hazir                             <= 1'b0;
         bellek_istek_adres_o                      <= '0;
         bellek_istek_gecerli_o                    <= 1'b0;
         anabellek_denetleyici_okuma_istek_hazir_o <= 1'b0;
      end else begin
         anabellek_denetleyici_okuma_istek_hazir_o <= 1'b0;
         if (!anabellek_denetleyici_okuma_istek_gecerli_i || farkli_blok) begin
            yeniden_hazir <= 1'b1;
         end
         case (durum)
            BOSTA: begin
               if (kabul) begin
                  taban                  <= giris_taban;
                  sayac                  <= '0;
                  bellek_istek_gecerli_o <= 1'b1;
                  bellek_istek_adres_o   <= kelime_adresi(giris_taban, baslangic_giris);
                  durum                  <= ISTEK;
               end
            end
            ISTEK: begin
               if (bellek_istek_hazir_i) begin
                  bellek_istek_gecerli_o <= 1'b0;
                  durum                  <= YANIT_BEKLE;
               end
            end
            YANIT_BEKLE: begin
               if (bellek_yanit_gecerli_i) begin
                  if (sayac == SIRA_BIT'(SOZCUK_SAYISI - 1)) begin
                     anabellek_denetleyici_okuma_istek_hazir_o <= 1'b1;
                     durum                                     <= TAMAM;
                  end else begin
                     sayac                  <= sayac_sonraki;
                     bellek_istek_gecerli_o <= 1'b1;
                     bellek_istek_adres_o   <= kelime_adresi(taban, sayac_sonraki + baslangic);
                     durum                  <= ISTEK;
                  end
               end
            end
            TAMAM: begin
               // Clearing here overrides the re-arm set above.
               yeniden_hazir <= 1'b0;
               sunulan_blok  <= taban[ADRES_BIT-1:OFSET_BIT];
               durum         <= BOSTA;
            end
            default: durum <= BOSTA;
         endcase
      end
   end

   blok_toplayici u_blok_toplayici (
      .clk     (clk_i),
      .rst_n   (rst_ni),
      .temizle (kabul),
      .yaz     (yaz),
      .sira    (sira),
      .veri    (bellek_yanit_veri_i),
      .blok    (anabellek_denetleyici_okuma_veri_blok_o)
   );

endmodule

// File: tb/tb_anabellek_blok_okuyucu.sv
// Self-checking bench for anabellek_blok_okuyucu: behavioural memory with
// configurable ready wait and response latency, address/block reference model.
module tb_anabellek_blok_okuyucu;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [31:0]  istek_adres;
   logic         istek_gecerli;
   logic [127:0] blok;
   logic         hazir;
   logic [31:0]  mem_adres;
   logic         mem_gecerli;
   logic         mem_hazir;
   logic [31:0]  mem_veri;
   logic         mem_yanit;

   int karsilastirma = 0;
   int hata = 0;

   // memory model state
   bit          aktif = 1'b0;
   int          bekleme = 0;
   int          gecikme = 1;
   int          bekle_sayac = 0;
   int          yanit_sayac = 0;
   bit          yanit_bekliyor = 1'b0;
   bit          istek_goruldu = 1'b0;
   logic [31:0] ilk_adres;
   logic [31:0] yanit_adres;
   logic [31:0] adres_log[$];
   int          kararsiz = 0;
   int          cakisma = 0;
   int          darbe = 0;

   always #5 clk = ~clk;

   anabellek_blok_okuyucu dut (
      .clk_i                                       (clk),
      .rst_ni                                      (rst_n),
      .anabellek_denetleyici_okuma_istek_adres_i   (istek_adres),
      .anabellek_denetleyici_okuma_istek_gecerli_i (istek_gecerli),
      .anabellek_denetleyici_okuma_veri_blok_o     (blok),
      .anabellek_denetleyici_okuma_istek_hazir_o   (hazir),
      .bellek_istek_adres_o                        (mem_adres),
      .bellek_istek_gecerli_o                      (mem_gecerli),
      .bellek_istek_hazir_i                        (mem_hazir),
      .bellek_yanit_veri_i                         (mem_veri),
      .bellek_yanit_gecerli_i                      (mem_yanit)
   );

   // Reference model: address of the k-th word read for request a.
   function automatic logic [31:0] beklenen_adres(input logic [31:0] a, input int k);
      logic [31:0] t;
      int ilk;
      t = a & 32'hFFFF_FFF0;
      ilk = 0;
`ifdef KRITIK_SOZCUK_ONCE_EN
      ilk = int'((a % 16) / 4);
`endif
      return t + 32'(4 * ((ilk + k) % 4));
   endfunction

   // Reference model: slot j holds (base + 4j) ^ A5A5A5A5 regardless of order.
   function automatic logic [127:0] beklenen_blok(input logic [31:0] a);
      logic [31:0]  t;
      logic [127:0] b;
      t = a & 32'hFFFF_FFF0;
      for (int j = 0; j < 4; j++) b[32*j +: 32] = (t + 32'(4 * j)) ^ 32'hA5A5_A5A5;
      return b;
   endfunction

   // Memory: sample at negedge, drive ready/response for the next posedge.
   initial forever begin
      @(negedge clk);
      if (aktif) begin
         mem_hazir = 1'b0;
         mem_yanit = 1'b0;
         if (yanit_bekliyor) begin
            yanit_sayac--;
            if (yanit_sayac == 0) begin
               mem_yanit      = 1'b1;
               mem_veri       = yanit_adres ^ 32'hA5A5_A5A5;
               yanit_bekliyor = 1'b0;
            end
         end
         if (mem_gecerli === 1'b1) begin
            if (yanit_bekliyor) cakisma++;
            if (!istek_goruldu) begin
               istek_goruldu = 1'b1;
               ilk_adres     = mem_adres;
               bekle_sayac   = bekleme;
            end else if (mem_adres !== ilk_adres) begin
               kararsiz++;
            end
            if (bekle_sayac == 0) begin
               mem_hazir = 1'b1;
               adres_log.push_back(mem_adres);
               istek_goruldu  = 1'b0;
               yanit_bekliyor = 1'b1;
               yanit_sayac    = gecikme;
               yanit_adres    = mem_adres;
            end else begin
               bekle_sayac--;
            end
         end else if (istek_goruldu) begin
            kararsiz++;
         end
      end
   end

   initial forever begin
      @(posedge clk);
      #1;
      if (hazir === 1'b1) darbe++;
   end

   task automatic model_sifirla();
      istek_goruldu  = 1'b0;
      yanit_bekliyor = 1'b0;
      adres_log.delete();
      kararsiz = 0;
      cakisma  = 0;
      darbe    = 0;
      mem_hazir = 1'b0;
      mem_yanit = 1'b0;
   endtask

   // n = posedges from the sampling edge until hazir seen, -1 on timeout.
   task automatic hazir_bekle(output int n);
      n = 0;
      while (n < 400) begin
         @(posedge clk);
         #1;
         n++;
         if (hazir === 1'b1) return;
      end
      n = -1;
   endtask

   task automatic istek_sur(input logic [31:0] a, output int n);
      istek_adres   = a;
      istek_gecerli = 1'b1;
      hazir_bekle(n);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      karsilastirma++; if (blok !== '0) begin hata++; $display("FAIL reset_blok: got %h want 0", blok); end
      karsilastirma++; if (hazir !== 1'b0) begin hata++; $display("FAIL reset_hazir: got %b want 0", hazir); end
      karsilastirma++; if (mem_gecerli !== 1'b0) begin hata++; $display("FAIL reset_gecerli: got %b want 0", mem_gecerli); end
      karsilastirma++; if (mem_adres !== '0) begin hata++; $display("FAIL reset_adres: got %h want 0", mem_adres); end
      rst_n = 1'b1;
      aktif = 1'b1;
   endtask

   task automatic test_temel();
      int n;
      logic [31:0] a = 32'h0000_1234;
      model_sifirla(); bekleme = 0; gecikme = 1;
      repeat (2) @(posedge clk); #2;
      istek_sur(a, n);
      karsilastirma++; if (n !== 9) begin hata++; $display("FAIL temel_gecikme: got %0d want 9", n); end
      #1 istek_gecerli = 1'b0;
      @(posedge clk); #1;
      karsilastirma++; if (hazir !== 1'b0) begin hata++; $display("FAIL temel_darbe_sonu: got %b want 0", hazir); end
      karsilastirma++; if (blok !== beklenen_blok(a)) begin hata++; $display("FAIL temel_blok: got %h want %h", blok, beklenen_blok(a)); end
      karsilastirma++; if (adres_log.size() != 4) begin hata++; $display("FAIL temel_istek_sayisi: got %0d want 4", adres_log.size()); end
      for (int k = 0; k < 4; k++) begin
         logic [31:0] g = (k < adres_log.size()) ? adres_log[k] : 'x;
         karsilastirma++; if (g !== beklenen_adres(a, k)) begin hata++; $display("FAIL temel_adres%0d: got %h want %h", k, g, beklenen_adres(a, k)); end
      end
      karsilastirma++; if (darbe != 1) begin hata++; $display("FAIL temel_darbe_sayisi: got %0d want 1", darbe); end
   endtask

   task automatic test_bekleme();
      int n;
      logic [31:0] a = 32'h0000_5678;
      model_sifirla(); bekleme = 3; gecikme = 5;
      repeat (2) @(posedge clk); #2;
      istek_sur(a, n);
      #1 istek_gecerli = 1'b0;
      repeat (3) @(posedge clk); #1;
      karsilastirma++; if (n < 0) begin hata++; $display("FAIL bekleme_zaman_asimi: got %0d want >0", n); end
      karsilastirma++; if (kararsiz != 0) begin hata++; $display("FAIL bekleme_kararlilik: got %0d want 0", kararsiz); end
      karsilastirma++; if (cakisma != 0) begin hata++; $display("FAIL bekleme_cakisma: got %0d want 0", cakisma); end
      karsilastirma++; if (adres_log.size() != 4) begin hata++; $display("FAIL bekleme_istek_sayisi: got %0d want 4", adres_log.size()); end
      karsilastirma++; if (darbe != 1) begin hata++; $display("FAIL bekleme_darbe: got %0d want 1", darbe); end
      karsilastirma++; if (blok !== beklenen_blok(a)) begin hata++; $display("FAIL bekleme_blok: got %h want %h", blok, beklenen_blok(a)); end
   endtask

   task automatic test_rastgele();
      int n;
      logic [31:0] a;
      for (int i = 0; i < 8; i++) begin
         model_sifirla();
         bekleme = $urandom_range(0, 3);
         gecikme = $urandom_range(1, 4);
         a = $urandom;
         repeat (2) @(posedge clk); #2;
         istek_sur(a, n);
         #1 istek_gecerli = 1'b0;
         karsilastirma++; if (n < 0) begin hata++; $display("FAIL rastgele%0d_zaman: timeout", i); end
         karsilastirma++; if (blok !== beklenen_blok(a)) begin hata++; $display("FAIL rastgele%0d_blok: got %h want %h", i, blok, beklenen_blok(a)); end
         for (int k = 0; k < 4; k++) begin
            logic [31:0] g = (k < adres_log.size()) ? adres_log[k] : 'x;
            karsilastirma++; if (g !== beklenen_adres(a, k)) begin hata++; $display("FAIL rastgele%0d_adres%0d: got %h want %h", i, k, g, beklenen_adres(a, k)); end
         end
         karsilastirma++; if (kararsiz + cakisma != 0) begin hata++; $display("FAIL rastgele%0d_protokol: got %0d want 0", i, kararsiz + cakisma); end
      end
   endtask

   task automatic test_yeniden();
      int n;
      int ekstra = 0;
      model_sifirla(); bekleme = 0; gecikme = 1;
      repeat (2) @(posedge clk); #2;
      istek_sur(32'h0000_0100, n);
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         if (mem_gecerli !== 1'b0) ekstra++;
      end
      karsilastirma++; if (ekstra != 0) begin hata++; $display("FAIL yeniden_tekrar: got %0d want 0", ekstra); end
      karsilastirma++; if (adres_log.size() != 4) begin hata++; $display("FAIL yeniden_istek_sayisi: got %0d want 4", adres_log.size()); end
      karsilastirma++; if (darbe != 1) begin hata++; $display("FAIL yeniden_darbe: got %0d want 1", darbe); end
      #1 istek_adres = 32'h0000_0200;
      @(posedge clk); #1;
      karsilastirma++; if (mem_gecerli !== 1'b1) begin hata++; $display("FAIL yeniden_yeni_basla: got %b want 1", mem_gecerli); end
      karsilastirma++; if (mem_adres !== beklenen_adres(32'h200, 0)) begin hata++; $display("FAIL yeniden_yeni_adres: got %h want %h", mem_adres, beklenen_adres(32'h200, 0)); end
      hazir_bekle(n);
      #1 istek_gecerli = 1'b0;
      karsilastirma++; if (n < 0) begin hata++; $display("FAIL yeniden_zaman: timeout"); end
      karsilastirma++; if (blok !== beklenen_blok(32'h200)) begin hata++; $display("FAIL yeniden_blok: got %h want %h", blok, beklenen_blok(32'h200)); end
   endtask

   task automatic test_reset_ortasi();
      int n;
      int c = 0;
      model_sifirla(); bekleme = 0; gecikme = 5;
      repeat (2) @(posedge clk); #2;
      istek_adres   = 32'h0000_3000;
      istek_gecerli = 1'b1;
      while (adres_log.size() < 2 && c < 100) begin
         @(posedge clk); #2;
         c++;
      end
      karsilastirma++; if (adres_log.size() < 2) begin hata++; $display("FAIL reset_ortasi_ulasma: got %0d want 2", adres_log.size()); end
      aktif = 1'b0; mem_hazir = 1'b0; mem_yanit = 1'b0;
      istek_gecerli = 1'b0;
      rst_n = 1'b0;
      #1;
      karsilastirma++; if (blok !== '0) begin hata++; $display("FAIL reset_ortasi_blok: got %h want 0", blok); end
      karsilastirma++; if (hazir !== 1'b0 || mem_gecerli !== 1'b0) begin hata++; $display("FAIL reset_ortasi_cikis: got %b%b want 00", hazir, mem_gecerli); end
      karsilastirma++; if (mem_adres !== '0) begin hata++; $display("FAIL reset_ortasi_adres: got %h want 0", mem_adres); end
      @(posedge clk); #2 rst_n = 1'b1;
      @(posedge clk); #2;
      mem_veri  = 32'hDEAD_BEEF;
      mem_yanit = 1'b1;
      @(posedge clk); #1;
      karsilastirma++; if (blok !== '0 || mem_gecerli !== 1'b0) begin hata++; $display("FAIL reset_eski_yanit: got %h/%b want 0/0", blok, mem_gecerli); end
      #1 mem_yanit = 1'b0;
      model_sifirla(); gecikme = 1; aktif = 1'b1;
      repeat (2) @(posedge clk); #2;
      istek_sur(32'h0000_3000, n);
      #1 istek_gecerli = 1'b0;
      karsilastirma++; if (n !== 9) begin hata++; $display("FAIL reset_sonrasi_gecikme: got %0d want 9", n); end
      karsilastirma++; if (blok !== beklenen_blok(32'h3000)) begin hata++; $display("FAIL reset_sonrasi_blok: got %h want %h", blok, beklenen_blok(32'h3000)); end
   endtask

   task automatic test_sarma();
      int n;
      int sifir = 0;
      logic [31:0] a = 32'hFFFF_FFF0;
      logic [31:0] son;
      model_sifirla(); bekleme = 1; gecikme = 2;
      repeat (2) @(posedge clk); #2;
      istek_sur(a, n);
      #1 istek_gecerli = 1'b0;
      foreach (adres_log[i]) if (adres_log[i] == 32'h0) sifir++;
      son = (adres_log.size() == 4) ? adres_log[3] : 'x;
      karsilastirma++; if (son !== 32'hFFFF_FFFC) begin hata++; $display("FAIL sarma_son_adres: got %h want fffffffc", son); end
      karsilastirma++; if (sifir != 0) begin hata++; $display("FAIL sarma_sifir_erisim: got %0d want 0", sifir); end
      karsilastirma++; if (blok !== beklenen_blok(a)) begin hata++; $display("FAIL sarma_blok: got %h want %h", blok, beklenen_blok(a)); end
   endtask

   task automatic test_kritik();
      int n;
      logic [31:0] a = 32'h0000_0048;
      logic [31:0] ilk;
      model_sifirla(); bekleme = 0; gecikme = 1;
      repeat (2) @(posedge clk); #2;
      istek_sur(a, n);
      #1 istek_gecerli = 1'b0;
      for (int k = 0; k < 4; k++) begin
         logic [31:0] g = (k < adres_log.size()) ? adres_log[k] : 'x;
         karsilastirma++; if (g !== beklenen_adres(a, k)) begin hata++; $display("FAIL kritik_adres%0d: got %h want %h", k, g, beklenen_adres(a, k)); end
      end
      ilk = (adres_log.size() > 0) ? adres_log[0] : 'x;
`ifdef KRITIK_SOZCUK_ONCE_EN
      karsilastirma++; if (ilk !== 32'h48) begin hata++; $display("FAIL kritik_ilk: got %h want 48", ilk); end
`else
      karsilastirma++; if (ilk !== 32'h40) begin hata++; $display("FAIL kritik_ilk: got %h want 40", ilk); end
`endif
      karsilastirma++; if (n !== 9) begin hata++; $display("FAIL kritik_gecikme: got %0d want 9", n); end
      karsilastirma++; if (blok !== beklenen_blok(a)) begin hata++; $display("FAIL kritik_blok: got %h want %h", blok, beklenen_blok(a)); end
   endtask

   initial begin
      rst_n = 1'b0; istek_gecerli = 1'b0; istek_adres = '0;
      mem_hazir = 1'b0; mem_yanit = 1'b0; mem_veri = '0;
      test_reset();
      test_temel();
      test_bekleme();
      test_rastgele();
      test_yeniden();
      test_reset_ortasi();
      test_sarma();
      test_kritik();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", karsilastirma, hata);
      $finish;
   end

endmodule
